// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory response block.
package dmem_pkg;

  localparam int unsigned DepthWordsDefault = 1024;

  localparam logic [2:0] LoadLw  = 3'b000;
  localparam logic [2:0] LoadLb  = 3'b001;
  localparam logic [2:0] LoadLbu = 3'b010;
  localparam logic [2:0] LoadLh  = 3'b011;
  localparam logic [2:0] LoadLhu = 3'b100;

  localparam logic [1:0] StoreSw = 2'b00;
  localparam logic [1:0] StoreSb = 2'b01;
  localparam logic [1:0] StoreSh = 2'b10;

  typedef logic [3:0] byte_mask_t;

  // Byte lanes touched by a store; halfwords use addr[1], words take all four lanes.
  function automatic byte_mask_t store_mask(input logic [1:0] st, input logic [1:0] off);
    byte_mask_t m;
    case (st)
      StoreSb: m = byte_mask_t'(4'b0001 << off);
      StoreSh: m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// CPU-side data-memory bus: store request, load type and load response.
interface dmem_resp_if;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [2:0]  Load;
  logic [1:0]  Store;
  logic [31:0] MemRedData;
  logic        wb_valid;
  logic        err_misalign;

  modport master (
    output MemWrite, addr, writedata, Load, Store,
    input  MemRedData, wb_valid, err_misalign
  );

  modport slave (
    input  MemWrite, addr, writedata, Load, Store,
    output MemRedData, wb_valid, err_misalign
  );
endinterface

// File: rtl/dmem_wbuf.sv
// One-entry store buffer: captures a store, commits it on the next edge, and
// forwards its bytes into same-index reads while it is pending.
module dmem_wbuf import dmem_pkg::*; #(
  parameter int unsigned IdxW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            st_en,
  input  logic [IdxW-1:0] st_idx,
  input  byte_mask_t      st_mask,
  input  logic [31:0]     st_data,
  input  logic [IdxW-1:0] rd_idx,
  input  logic [31:0]     arr_word,
  output logic [31:0]     merged_word,
  output logic            commit_en,
  output logic [IdxW-1:0] commit_idx,
  output byte_mask_t      commit_mask,
  output logic [31:0]     commit_data,
  output logic            valid
);

  logic            valid_q;
  logic [IdxW-1:0] idx_q;
  byte_mask_t      mask_q;
  logic [31:0]     data_q;

  // A new store replaces the entry in the same edge the old one commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= st_en;
      if (st_en) begin
        idx_q  <= st_idx;
        mask_q <= st_mask;
        data_q <= st_data;
      end
    end
  end

  assign commit_en   = valid_q & ~rst;
  assign commit_idx  = idx_q;
  assign commit_mask = mask_q;
  assign commit_data = data_q;
  assign valid       = valid_q;

  always_comb begin
    merged_word = arr_word;
    for (int b = 0; b < 4; b++) begin
      if (valid_q && (idx_q == rd_idx) && mask_q[b]) begin
        merged_word[8*b +: 8] = data_q[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Data memory with write buffer, lane select and load extension.
// Optional misalignment checking is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_resp import dmem_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = DepthWordsDefault
) (
  input logic        clk,
  input logic        rst,
  dmem_resp_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  logic [31:0]     mem [DEPTH_WORDS];
  logic [IdxW-1:0] idx;
  logic [1:0]      off;
  logic            unused_addr;

  assign idx         = bus.addr[IdxW+1:2];
  assign off         = bus.addr[1:0];
  assign unused_addr = ^bus.addr[31:IdxW+2];

  logic [31:0] st_data;
  byte_mask_t  st_mask;
  logic        st_en;
  logic        st_mis;
  logic        ld_mis;

  always_comb begin
    case (bus.Store)
      StoreSb: st_data = {4{bus.writedata[7:0]}};
      StoreSh: st_data = {2{bus.writedata[15:0]}};
      default: st_data = bus.writedata;
    endcase
  end

  assign st_mask = store_mask(bus.Store, off);

`ifdef DMEM_MISALIGN_CHK_EN
  logic err_q;

  always_comb begin
    case (bus.Store)
      StoreSb: st_mis = 1'b0;
      StoreSh: st_mis = off[0];
      default: st_mis = (off != 2'b00);
    endcase
    case (bus.Load)
      LoadLb, LoadLbu: ld_mis = 1'b0;
      LoadLh, LoadLhu: ld_mis = off[0];
      default:         ld_mis = (off != 2'b00);
    endcase
  end

  // Loads carry no request qualifier, so only stores raise the sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.MemWrite && st_mis) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_misalign = err_q;
`else
  assign st_mis           = 1'b0;
  assign ld_mis           = 1'b0;
  assign bus.err_misalign = 1'b0;
`endif

  assign st_en = bus.MemWrite & ~st_mis;

  logic [31:0]     arr_word;
  logic [31:0]     word;
  logic            commit_en;
  logic [IdxW-1:0] commit_idx;
  byte_mask_t      commit_mask;
  logic [31:0]     commit_data;

  assign arr_word = mem[idx];

  dmem_wbuf #(
    .IdxW(IdxW)
  ) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .st_en      (st_en),
    .st_idx     (idx),
    .st_mask    (st_mask),
    .st_data    (st_data),
    .rd_idx     (idx),
    .arr_word   (arr_word),
    .merged_word(word),
    .commit_en  (commit_en),
    .commit_idx (commit_idx),
    .commit_mask(commit_mask),
    .commit_data(commit_data),
    .valid      (bus.wb_valid)
  );

  // Array contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (commit_en) begin
      for (int b = 0; b < 4; b++) begin
        if (commit_mask[b]) begin
          mem[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
        end
      end
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] rd_data;

  always_comb begin
    ld_byte = word[8*off +: 8];
    ld_half = off[1] ? word[31:16] : word[15:0];
    case (bus.Load)
      LoadLb:  rd_data = {{24{ld_byte[7]}}, ld_byte};
      LoadLbu: rd_data = {24'h0, ld_byte};
      LoadLh:  rd_data = {{16{ld_half[15]}}, ld_half};
      LoadLhu: rd_data = {16'h0, ld_half};
      default: rd_data = word;
    endcase
    if (ld_mis) begin
      rd_data = 32'h0;
    end
  end

  assign bus.MemRedData = rd_data;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp against a byte-addressed reference model.
module tb_dmem_resp;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Bytes = Depth * 4;

  localparam logic [2:0] LW = 3'b000, LB = 3'b001, LBU = 3'b010, LH = 3'b011, LHU = 3'b100;
  localparam logic [1:0] SW = 2'b00, SB = 2'b01, SH = 2'b10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_resp_if bus();

  dmem_resp #(
    .DEPTH_WORDS(Depth)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: committed bytes plus the bytes of the one store not yet committed.
  logic [7:0]  mem_b [Bytes];
  int unsigned p_addr[$];
  logic [7:0]  p_byte[$];
  logic        err_m = 1'b0;

  function automatic logic [7:0] view(input int unsigned a);
    for (int i = p_addr.size() - 1; i >= 0; i--) begin
      if (p_addr[i] == a) return p_byte[i];
    end
    return mem_b[a];
  endfunction

  function automatic bit mis_st(input logic [1:0] st, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHK_EN
    if (st == SB) return 1'b0;
    if (st == SH) return a[0];
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit mis_ld(input logic [2:0] ld, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHK_EN
    if (ld == LB || ld == LBU) return 1'b0;
    if (ld == LH || ld == LHU) return a[0];
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] ld, input logic [31:0] a);
    int unsigned aa = a % Bytes;
    int unsigned base;
    logic [7:0]  b;
    logic [15:0] h;
    if (mis_ld(ld, a)) return 32'h0;
    case (ld)
      LB, LBU: begin
        b = view(aa);
        return (ld == LB) ? {{24{b[7]}}, b} : {24'h0, b};
      end
      LH, LHU: begin
        base = aa & ~32'd1;
        h = {view(base + 1), view(base)};
        return (ld == LH) ? {{16{h[15]}}, h} : {16'h0, h};
      end
      default: begin
        base = aa & ~32'd3;
        return {view(base + 3), view(base + 2), view(base + 1), view(base)};
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] ld, input logic [1:0] st, input logic r,
                      input bit chk_rd);
    int unsigned aa;
    int unsigned base;
    bus.MemWrite  = mw;
    bus.addr      = a;
    bus.writedata = wd;
    bus.Load      = ld;
    bus.Store     = st;
    rst           = r;
    @(negedge clk);
    if (chk_rd) chk("rd", bus.MemRedData, model_load(ld, a));
    chk("wb_valid", {31'h0, bus.wb_valid}, {31'h0, p_addr.size() != 0});
    chk("err", {31'h0, bus.err_misalign}, {31'h0, err_m});
    @(posedge clk);
    if (r) begin
      p_addr.delete();
      p_byte.delete();
      err_m = 1'b0;
    end else begin
      foreach (p_addr[i]) mem_b[p_addr[i]] = p_byte[i];
      p_addr.delete();
      p_byte.delete();
      if (mw && mis_st(st, a)) begin
        err_m = 1'b1;
      end else if (mw) begin
        aa = a % Bytes;
        case (st)
          SB: begin
            p_addr.push_back(aa);
            p_byte.push_back(wd[7:0]);
          end
          SH: begin
            base = aa & ~32'd1;
            for (int k = 0; k < 2; k++) begin
              p_addr.push_back(base + k);
              p_byte.push_back(wd[8*k +: 8]);
            end
          end
          default: begin
            base = aa & ~32'd3;
            for (int k = 0; k < 4; k++) begin
              p_addr.push_back(base + k);
              p_byte.push_back(wd[8*k +: 8]);
            end
          end
        endcase
      end
    end
    #1;
  endtask

  task automatic peek(input logic [2:0] ld, input logic [31:0] a);
    bus.MemWrite = 1'b0;
    bus.Load     = ld;
    bus.addr     = a;
    rst          = 1'b0;
    #1;
  endtask

  logic [31:0] prior;
  logic [31:0] prior44;

  initial begin
    step(1'b0, 32'h0, 32'h0, LW, SW, 1'b1, 1'b0);
    step(1'b1, 32'h40, 32'h5555_5555, LW, SW, 1'b1, 1'b0);
    for (int i = 0; i < int'(Depth); i++) begin
      step(1'b1, i * 4, $urandom, LW, SW, 1'b0, 1'b0);
    end
    step(1'b0, 32'h0, 32'h0, LW, SW, 1'b0, 1'b1);

    // Forwarding, then array read after drain.
    step(1'b1, 32'h10, 32'h1122_3344, LW, SW, 1'b0, 1'b1);
    peek(LW, 32'h10);
    chk("fwd_lw", bus.MemRedData, 32'h1122_3344);
    chk("fwd_wbv", {31'h0, bus.wb_valid}, 32'h1);
    step(1'b0, 32'h10, 32'h0, LW, SW, 1'b0, 1'b1);
    step(1'b0, 32'h10, 32'h0, LW, SW, 1'b0, 1'b1);
    peek(LW, 32'h10);
    chk("arr_lw", bus.MemRedData, 32'h1122_3344);
    chk("arr_wbv", {31'h0, bus.wb_valid}, 32'h0);

    peek(LB, 32'h13);
    chk("lb_13", bus.MemRedData, 32'h0000_0011);
    step(1'b1, 32'h11, 32'h0000_0080, LB, SB, 1'b0, 1'b1);
    peek(LB, 32'h11);
    chk("lb_11", bus.MemRedData, 32'hFFFF_FF80);
    peek(LBU, 32'h11);
    chk("lbu_11", bus.MemRedData, 32'h0000_0080);

    step(1'b1, 32'h20, 32'h0000_BEEF, LW, SH, 1'b0, 1'b1);
    step(1'b1, 32'h22, 32'h0000_CAFE, LW, SH, 1'b0, 1'b1);
    peek(LW, 32'h20);
    chk("sh_fwd", bus.MemRedData, 32'hCAFE_BEEF);
    step(1'b0, 32'h20, 32'h0, LW, SW, 1'b0, 1'b1);
    step(1'b0, 32'h20, 32'h0, LW, SW, 1'b0, 1'b1);
    peek(LW, 32'h20);
    chk("sh_arr", bus.MemRedData, 32'hCAFE_BEEF);

    // Reset discards a buffered store and one presented in the reset cycle.
    prior   = model_load(LW, 32'h40);
    prior44 = model_load(LW, 32'h44);
    step(1'b1, 32'h40, 32'hDEAD_BEEF, LW, SW, 1'b0, 1'b1);
    step(1'b1, 32'h44, 32'h0BAD_F00D, LW, SW, 1'b1, 1'b1);
    peek(LW, 32'h40);
    chk("rst_wbv", {31'h0, bus.wb_valid}, 32'h0);
    chk("rst_rd40", bus.MemRedData, prior);
    step(1'b0, 32'h44, 32'h0, LW, SW, 1'b0, 1'b1);
    peek(LW, 32'h44);
    chk("rst_rd44", bus.MemRedData, prior44);

    step(1'b1, 32'h41, 32'h1234_5678, LW, SW, 1'b0, 1'b1);
    step(1'b0, 32'h40, 32'h0, LW, SW, 1'b0, 1'b1);
    step(1'b0, 32'h40, 32'h0, LW, SW, 1'b0, 1'b1);
    peek(LW, 32'h40);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("mis_rd", bus.MemRedData, prior);
    chk("mis_err", {31'h0, bus.err_misalign}, 32'h1);
    peek(LH, 32'h43);
    chk("mis_lh", bus.MemRedData, 32'h0);
    step(1'b0, 32'h0, 32'h0, LW, SW, 1'b1, 1'b0);
    peek(LW, 32'h0);
    chk("mis_clr", {31'h0, bus.err_misalign}, 32'h0);
`else
    chk("unal_sw", bus.MemRedData, 32'h1234_5678);
    chk("unal_err", {31'h0, bus.err_misalign}, 32'h0);
`endif

    step(1'b1, 32'h1000, 32'hA5A5_A5A5, LW, SW, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, LW, SW, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, LW, SW, 1'b0, 1'b1);
    peek(LW, 32'h0);
    chk("wrap", bus.MemRedData, 32'hA5A5_A5A5);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = {20'h0, a[11:0]} & 32'h0000_00FF;
      step($urandom_range(0, 1) == 1, a, $urandom, 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), $urandom_range(0, 63) == 0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
